// File: rtl/ffd_window_delay_if.sv
// Sample stream and window status bundle for the energy-detector delay line.
// master drives samples and controls; slave is the delay line itself.
interface ffd_window_delay_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 7
);
    logic             clr;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] fill;
    logic             full;
    logic             len_err;

    modport master (
        output clr, len, in_valid, in_data,
        input  out_valid, out_data, fill, full, len_err
    );

    modport slave (
        input  clr, len, in_valid, in_data,
        output out_valid, out_data, fill, full, len_err
    );
endinterface

// File: rtl/ffd_window_delay.sv
// Qualified WIDTH-bit delay line with run-time window length, departing-sample
// tap and fill tracking for the adaptive-threshold energy detector.
module ffd_window_delay #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 64,
    parameter int CNT_W = 7
) (
    input  logic               clk,
    input  logic               rst,
    ffd_window_delay_if.slave  bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [1:0]       sync;
    logic             run;
    logic             shift;
    logic             len_ok;
    logic             len_change;
    logic             full_int;
    logic [IDX_W-1:0] tap_idx;
    logic [CNT_W-1:0] fill_next;

    logic [WIDTH-1:0] stage [DEPTH];
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] fill_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             len_err_q;

    // Reset release is retimed so no register leaves reset on a partial edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], 1'b1};
        end
    end

    assign run        = sync[1];
    assign shift      = run && bus.in_valid;
    assign len_ok     = (bus.len != '0) && (bus.len <= CNT_W'(DEPTH));
    assign len_change = len_ok && (bus.len != len_q);
    assign full_int   = (fill_q == len_q);
    assign tap_idx    = IDX_W'(len_q - CNT_W'(1));

    always_comb begin
        fill_next = fill_q;
        if (bus.clr || len_change) begin
            fill_next = '0;
        end else if (shift && (fill_q < len_q)) begin
            fill_next = fill_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else if (shift) begin
            stage[0] <= bus.in_data;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    // The tap is read before the shift, so it is the sample leaving the window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q       <= CNT_W'(1);
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            len_err_q   <= 1'b0;
        end else if (run) begin
            if (!len_ok) begin
                len_err_q <= 1'b1;
            end
            if (len_change) begin
                len_q <= bus.len;
            end
            fill_q      <= fill_next;
            out_valid_q <= shift && full_int && !bus.clr;
            if (shift) begin
                out_data_q <= stage[tap_idx];
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.fill      = fill_q;
    assign bus.full      = full_int;
    assign bus.len_err   = len_err_q;
endmodule

// File: tb/tb_ffd_window_delay.sv
// Directed and randomized checks of ffd_window_delay against a queue-based
// model of the sample history.
module tb_ffd_window_delay;
    localparam int WIDTH = 16;
    localparam int DEPTH = 64;
    localparam int CNT_W = 7;

    logic clk = 1'b0;
    logic rst = 1'b0;

    ffd_window_delay_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus_if ();

    ffd_window_delay #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // History of accepted samples, newest first; starts as DEPTH zeros.
    logic [WIDTH-1:0] hist [$];
    int               m_fill;
    int               m_len;
    bit               m_ov;
    logic [WIDTH-1:0] m_od;
    bit               m_err;
    string            phase;
    int               stepno;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h (failure %0d)", tag, obs, exp, fails);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < DEPTH; i++) hist.push_back('0);
        m_fill = 0;
        m_len  = 1;
        m_ov   = 1'b0;
        m_od   = '0;
        m_err  = 1'b0;
    endtask

    task automatic model_update(input bit v, input logic [WIDTH-1:0] d, input bit c, input int l);
        bit legal;
        bit changed;
        bit full_before;
        legal       = (l >= 1) && (l <= DEPTH);
        changed     = legal && (l != m_len);
        full_before = (m_fill == m_len);
        if (v) begin
            m_od = hist[m_len-1];
            m_ov = full_before && !c;
            hist.push_front(d);
            void'(hist.pop_back());
        end else begin
            m_ov = 1'b0;
        end
        if (c || changed) m_fill = 0;
        else if (v && m_fill < m_len) m_fill = m_fill + 1;
        if (!legal) m_err = 1'b1;
        if (changed) m_len = l;
    endtask

    task automatic compare_all();
        string t;
        t = $sformatf("%s#%0d", phase, stepno);
        check({t, ".out_data"},  32'(bus_if.out_data),  32'(m_od));
        check({t, ".out_valid"}, 32'(bus_if.out_valid), 32'(m_ov));
        check({t, ".fill"},      32'(bus_if.fill),      32'(m_fill));
        check({t, ".full"},      32'(bus_if.full),      32'(m_fill == m_len));
        check({t, ".len_err"},   32'(bus_if.len_err),   32'(m_err));
    endtask

    // One clock: drive inputs, take the edge, advance the model if it is live.
    task automatic step(input bit v, input logic [WIDTH-1:0] d, input bit c, input int l, input bit live);
        bus_if.in_valid = v;
        bus_if.in_data  = d;
        bus_if.clr      = c;
        bus_if.len      = CNT_W'(l);
        @(posedge clk);
        #1;
        stepno++;
        if (live) model_update(v, d, c, l);
        compare_all();
    endtask

    initial begin
        int cur_len;
        int l;
        bit v;
        int gap_v [6];
        int di;
        logic [WIDTH-1:0] gap_d [4];

        gap_v = '{1, 0, 1, 0, 1, 1};
        gap_d = '{16'd10, 16'd20, 16'd30, 16'd40};
        stepno = 0;
        model_reset();
        bus_if.in_valid = 1'b0;
        bus_if.in_data  = '0;
        bus_if.clr      = 1'b0;
        bus_if.len      = CNT_W'(4);

        phase = "reset";
        for (int i = 0; i < 3; i++) step(1'b1, 16'h5555, 1'b0, 4, 1'b0);

        rst = 1'b1;
        phase = "sync";
        for (int i = 0; i < 2; i++) step(1'b1, 16'h1234, 1'b0, 4, 1'b0);

        phase = "basic";
        step(1'b0, '0, 1'b0, 4, 1'b1);
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, WIDTH'(i), 1'b0, 4, 1'b1);
            if (i == 4) check("basic_full_after_4", 32'(bus_if.full), 32'd1);
            if (i == 5) begin
                check("basic_first_out_data", 32'(bus_if.out_data), 32'd1);
                check("basic_first_out_valid", 32'(bus_if.out_valid), 32'd1);
            end
        end

        phase = "gapped";
        step(1'b0, '0, 1'b0, 3, 1'b1);
        di = 0;
        for (int i = 0; i < 6; i++) begin
            if (gap_v[i] == 1) begin
                step(1'b1, gap_d[di], 1'b0, 3, 1'b1);
                di++;
            end else begin
                step(1'b0, 16'hDEAD, 1'b0, 3, 1'b1);
            end
        end
        check("gapped_out_data", 32'(bus_if.out_data), 32'd10);
        check("gapped_out_valid", 32'(bus_if.out_valid), 32'd1);

        phase = "lenchg";
        step(1'b0, '0, 1'b0, 8, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, WIDTH'(100 + i), 1'b0, 8, 1'b1);
        check("len8_full", 32'(bus_if.full), 32'd1);
        step(1'b0, '0, 1'b0, 5, 1'b1);
        check("len5_fill_restart", 32'(bus_if.fill), 32'd0);
        check("len5_full_restart", 32'(bus_if.full), 32'd0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, WIDTH'(200 + i), 1'b0, 5, 1'b1);
            if (i == 4) check("len5_full_again", 32'(bus_if.full), 32'd1);
        end

        phase = "clr";
        step(1'b1, 16'hAAAA, 1'b1, 5, 1'b1);
        check("clr_fill", 32'(bus_if.fill), 32'd0);
        check("clr_out_valid", 32'(bus_if.out_valid), 32'd0);
        for (int i = 0; i < 5; i++) step(1'b1, WIDTH'(300 + i), 1'b0, 5, 1'b1);
        check("clr_sample_emerges", 32'(bus_if.out_data), 32'hAAAA);

        phase = "illegal";
        step(1'b0, '0, 1'b0, 0, 1'b1);
        check("len0_err", 32'(bus_if.len_err), 32'd1);
        step(1'b0, '0, 1'b0, 5, 1'b1);
        check("len0_no_restart", 32'(bus_if.fill), 32'd5);
        step(1'b0, '0, 1'b0, 100, 1'b1);
        step(1'b0, '0, 1'b0, 5, 1'b1);
        check("len_err_sticky", 32'(bus_if.len_err), 32'd1);

        phase = "maxdepth";
        step(1'b0, '0, 1'b0, DEPTH, 1'b1);
        for (int i = 1; i <= 70; i++) begin
            step(1'b1, WIDTH'(16'h1000 + i), 1'b0, DEPTH, 1'b1);
            if (i == 64) check("max_full", 32'(bus_if.full), 32'd1);
            if (i == 65) check("max_delay64", 32'(bus_if.out_data), 32'h1001);
        end
        check("max_fill_sat", 32'(bus_if.fill), 32'd64);

        phase = "random";
        cur_len = DEPTH;
        for (int i = 0; i < 400; i++) begin
            l = cur_len;
            if ($urandom_range(0, 19) == 0) begin
                l = int'($urandom_range(0, 70));
                if (l >= 1 && l <= DEPTH) cur_len = l;
            end else if ($urandom_range(0, 29) == 0) begin
                l = int'($urandom_range(1, 12));
                cur_len = l;
            end
            v = ($urandom_range(0, 9) < 7);
            step(v, WIDTH'($urandom), ($urandom_range(0, 19) == 0), l, 1'b1);
        end

        // Asynchronous reset mid-run must clear outputs without a clock edge.
        phase = "midreset";
        rst = 1'b0;
        #2;
        check("midrst_out_data", 32'(bus_if.out_data), 32'd0);
        check("midrst_out_valid", 32'(bus_if.out_valid), 32'd0);
        check("midrst_fill", 32'(bus_if.fill), 32'd0);
        check("midrst_full", 32'(bus_if.full), 32'd0);
        check("midrst_len_err", 32'(bus_if.len_err), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
